// File: rtl/fp_divider_iter_if.sv
// Operand/result handshake bundle for the iterative fp divider.
// master = operand producer / result consumer, slave = divider.
interface fp_divider_iter_if #(
  parameter int EXP_W  = 8,
  parameter int MANT_W = 23
);
  localparam int W = 1 + EXP_W + MANT_W;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in1;
  logic [W-1:0] in2;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         div_by_zero;
  logic         busy;

  modport master (
    output in_valid, in1, in2, out_ready,
    input  in_ready, out_valid, result, div_by_zero, busy
  );

  modport slave (
    input  in_valid, in1, in2, out_ready,
    output in_ready, out_valid, result, div_by_zero, busy
  );
endinterface

// File: rtl/fp_divider_iter.sv
// Sequential single-precision divider: restoring radix-2 mantissa division,
// one quotient bit per clock, truncating result, denormals flushed to zero.
module fp_divider_iter #(
  parameter int EXP_W  = 8,
  parameter int MANT_W = 23,
  parameter int BIAS   = 127
) (
  input  logic              clk,
  input  logic              rst_n,
  fp_divider_iter_if.slave  bus
);
  localparam int W   = 1 + EXP_W + MANT_W;
  localparam int QW  = MANT_W + 2;          // quotient bits produced
  localparam int RW  = MANT_W + 3;          // remainder: < 2*divisor after shift
  localparam int EW  = EXP_W + 2;           // signed exponent working width
  localparam int CW  = $clog2(QW);
  localparam logic [EXP_W-1:0] EMAX = '1;

  typedef enum logic [1:0] {IDLE, DIVIDE, NORM, DONE} state_t;

  state_t             state;
  logic               sign;
  logic [EXP_W-1:0]   ea, eb;
  logic [RW-1:0]      rem, dvs;
  logic [QW-1:0]      q;
  logic [CW-1:0]      cnt;
  logic               out_valid_r, dbz_r;
  logic [W-1:0]       result_r;

  // operand decode for the special-case check done at accept time
  logic [EXP_W-1:0] a_exp, b_exp;
  logic             a_zero, b_zero, in_sign;
  assign a_exp   = bus.in1[W-2:MANT_W];
  assign b_exp   = bus.in2[W-2:MANT_W];
  assign a_zero  = (a_exp == '0);
  assign b_zero  = (b_exp == '0);
  assign in_sign = bus.in1[W-1] ^ bus.in2[W-1];

  // one restoring step: subtract if it does not go negative
  logic          ge;
  logic [RW-1:0] diff;
  assign ge   = (rem >= dvs);
  assign diff = rem - dvs;

  // normalisation of the finished quotient; exponent kept wide so that
  // overflow and underflow are visible as out-of-range values
  logic [EW-1:0]     e_u;
  logic [MANT_W-1:0] mant_n;
  logic              ovf, unf;
  assign e_u    = {2'b00, ea} - {2'b00, eb} + EW'(BIAS) - {{(EW-1){1'b0}}, ~q[QW-1]};
  assign mant_n = q[QW-1] ? q[QW-2:1] : q[QW-3:0];
  assign unf    = e_u[EW-1] || (e_u == '0);
  assign ovf    = !e_u[EW-1] && (e_u >= {2'b00, EMAX});

  // control FSM plus datapath registers and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      sign        <= 1'b0;
      ea          <= '0;
      eb          <= '0;
      rem         <= '0;
      dvs         <= '0;
      q           <= '0;
      cnt         <= '0;
      out_valid_r <= 1'b0;
      dbz_r       <= 1'b0;
      result_r    <= '0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          sign <= in_sign;
          ea   <= a_exp;
          eb   <= b_exp;
          if (a_exp == EMAX || b_exp == EMAX || (a_zero && b_zero)) begin
            result_r    <= {1'b0, EMAX, 1'b1, {(MANT_W-1){1'b0}}};
            dbz_r       <= 1'b0;
            out_valid_r <= 1'b1;
            state       <= DONE;
          end else if (b_zero) begin
            result_r    <= {in_sign, EMAX, {MANT_W{1'b0}}};
            dbz_r       <= 1'b1;
            out_valid_r <= 1'b1;
            state       <= DONE;
          end else if (a_zero) begin
            result_r    <= {in_sign, {(W-1){1'b0}}};
            dbz_r       <= 1'b0;
            out_valid_r <= 1'b1;
            state       <= DONE;
          end else begin
            rem   <= {2'b01, bus.in1[MANT_W-1:0]};
            dvs   <= {2'b01, bus.in2[MANT_W-1:0]};
            q     <= '0;
            cnt   <= CW'(QW - 1);
            state <= DIVIDE;
          end
        end
        DIVIDE: begin
          q   <= {q[QW-2:0], ge};
          rem <= (ge ? diff : rem) << 1;
          cnt <= cnt - 1'b1;
          if (cnt == '0) state <= NORM;
        end
        NORM: begin
          if (ovf)      result_r <= {sign, EMAX, {MANT_W{1'b0}}};
          else if (unf) result_r <= {sign, {(W-1){1'b0}}};
          else          result_r <= {sign, e_u[EXP_W-1:0], mant_n};
          dbz_r       <= 1'b0;
          out_valid_r <= 1'b1;
          state       <= DONE;
        end
        DONE: if (bus.out_ready) begin
          out_valid_r <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready    = (state == IDLE);
  assign bus.busy        = (state != IDLE);
  assign bus.out_valid   = out_valid_r;
  assign bus.result      = result_r;
  assign bus.div_by_zero = dbz_r;
endmodule

// File: tb/tb_fp_divider_iter.sv
// Self-checking bench for fp_divider_iter: directed table, handshake/reset
// corner sequences, and random operands against an integer reference model.
module tb_fp_divider_iter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  fp_divider_iter_if bus();

  fp_divider_iter dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic        dbz;
    int          lat;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp_v);
    end
  endtask

  // reference: exact integer quotient truncated to 24 significant bits
  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic dbz, output int lat);
    int     ea, eb, e;
    logic   s;
    longint qq, mant;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    s  = a[31] ^ b[31];
    dbz = 1'b0;
    lat = 1;
    if (ea == 255 || eb == 255 || (ea == 0 && eb == 0)) r = 32'h7FC00000;
    else if (eb == 0) begin r = {s, 8'hFF, 23'h0}; dbz = 1'b1; end
    else if (ea == 0) r = {s, 31'h0};
    else begin
      lat = 26;
      qq = (longint'({1'b1, a[22:0]}) << 24) / longint'({1'b1, b[22:0]});
      if (qq >= (64'sd1 << 24)) begin mant = qq >> 1; e = ea - eb + 127; end
      else begin mant = qq; e = ea - eb + 126; end
      if (e >= 255)    r = {s, 8'hFF, 23'h0};
      else if (e <= 0) r = {s, 31'h0};
      else             r = {s, e[7:0], mant[22:0]};
    end
  endfunction

  // issue one op, wait for result, complete handshake
  task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] r, output logic dbz, output int lat);
    int n;
    @(negedge clk);
    n = 0;
    while (!bus.in_ready && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) chk("in_ready_timeout", 32'd0, 32'd1);
    bus.in1 = a;
    bus.in2 = b;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    bus.in1 = $urandom;
    bus.in2 = $urandom;
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      #1;
    end while (!bus.out_valid && lat < 100);
    r   = bus.result;
    dbz = bus.div_by_zero;
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
  endtask

  vec_t        tbl[$];
  logic [31:0] r, er;
  logic        dbz, edbz;
  int          lat, elat;

  function automatic logic [31:0] rnd_op();
    logic [31:0] v;
    int k;
    v = $urandom;
    k = $urandom_range(0, 9);
    if (k == 0)      v[30:23] = 8'h00;
    else if (k == 1) v[30:23] = 8'hFF;
    else if (k < 5)  v[30:23] = 8'($urandom_range(100, 154));
    else             v[30:23] = 8'($urandom_range(1, 254));
    return v;
  endfunction

  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.in1 = '0;
    bus.in2 = '0;

    tbl.push_back('{32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 26});
    tbl.push_back('{32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 1'b0, 26});
    tbl.push_back('{32'hBF800000, 32'h40400000, 32'hBEAAAAAA, 1'b0, 26});
    tbl.push_back('{32'hC1000000, 32'h00000000, 32'hFF800000, 1'b1, 1});
    tbl.push_back('{32'h00000000, 32'h00000000, 32'h7FC00000, 1'b0, 1});
    tbl.push_back('{32'h7F000000, 32'h00800000, 32'h7F800000, 1'b0, 26});
    tbl.push_back('{32'h00800000, 32'h7F000000, 32'h00000000, 1'b0, 26});
    tbl.push_back('{32'h00400000, 32'h3F800000, 32'h00000000, 1'b0, 1});
    tbl.push_back('{32'h7F800000, 32'h3F800000, 32'h7FC00000, 1'b0, 1});
    tbl.push_back('{32'h3F800000, 32'h7F800000, 32'h7FC00000, 1'b0, 1});
    tbl.push_back('{32'h80000000, 32'h3F800000, 32'h80000000, 1'b0, 1});
    tbl.push_back('{32'h3F800000, 32'h3F800000, 32'h3F800000, 1'b0, 26});
    tbl.push_back('{32'h3F800000, 32'h3FFFFFFF, 32'h3F000000, 1'b0, 26});
    tbl.push_back('{32'h7F000000, 32'h3F000000, 32'h7F800000, 1'b0, 26});
    tbl.push_back('{32'h7F000000, 32'h3F800000, 32'h7F000000, 1'b0, 26});
    tbl.push_back('{32'h00800000, 32'h3F800000, 32'h00800000, 1'b0, 26});
    tbl.push_back('{32'h00800000, 32'h40000000, 32'h00000000, 1'b0, 26});

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'h0, bus.out_valid}, 32'd0);
    chk("rst_result", bus.result, 32'd0);
    chk("rst_dbz", {31'h0, bus.div_by_zero}, 32'd0);
    chk("rst_busy", {31'h0, bus.busy}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    #1 chk("rst_in_ready", {31'h0, bus.in_ready}, 32'd1);

    // directed table
    foreach (tbl[i]) begin
      do_op(tbl[i].a, tbl[i].b, r, dbz, lat);
      chk($sformatf("tbl%0d_result", i), r, tbl[i].r);
      chk($sformatf("tbl%0d_dbz", i), {31'h0, dbz}, {31'h0, tbl[i].dbz});
      chk($sformatf("tbl%0d_latency", i), lat, tbl[i].lat);
    end

    // result held in DONE while consumer stalls; new operands ignored
    @(negedge clk);
    bus.in1 = 32'h40C00000; bus.in2 = 32'h40000000; bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    lat = 0;
    do begin @(posedge clk); lat++; #1; end while (!bus.out_valid && lat < 100);
    chk("hold_latency", lat, 26);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.in1 = 32'h3F800000; bus.in2 = 32'h40400000; bus.in_valid = 1'b1;
      @(posedge clk);
      #1;
      chk($sformatf("hold%0d_result", i), bus.result, 32'h40400000);
      chk($sformatf("hold%0d_in_ready", i), {31'h0, bus.in_ready}, 32'd0);
      chk($sformatf("hold%0d_out_valid", i), {31'h0, bus.out_valid}, 32'd1);
    end
    @(negedge clk);
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    chk("release_out_valid", {31'h0, bus.out_valid}, 32'd0);
    repeat (3) @(posedge clk);
    #1 chk("release_busy", {31'h0, bus.busy}, 32'd0);
    chk("release_no_valid", {31'h0, bus.out_valid}, 32'd0);

    // abort mid-divide with reset
    @(negedge clk);
    bus.in1 = 32'h40C00000; bus.in2 = 32'h40400000; bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_out_valid", {31'h0, bus.out_valid}, 32'd0);
    chk("abort_result", bus.result, 32'd0);
    chk("abort_busy", {31'h0, bus.busy}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    do_op(32'h3F800000, 32'h40400000, r, dbz, lat);
    chk("post_abort_result", r, 32'h3EAAAAAA);
    chk("post_abort_latency", lat, 26);

    // random operands against the model
    for (int i = 0; i < 150; i++) begin
      logic [31:0] a, b;
      a = rnd_op();
      b = rnd_op();
      model(a, b, er, edbz, elat);
      do_op(a, b, r, dbz, lat);
      chk($sformatf("rnd%0d_result(%h/%h)", i, a, b), r, er);
      chk($sformatf("rnd%0d_dbz", i), {31'h0, dbz}, {31'h0, edbz});
      chk($sformatf("rnd%0d_latency", i), lat, elat);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
